// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA controller among NUM_DEV peripherals.
// The grant is held from request through the controller's end flag.
module dma_req_arbiter #(
    parameter int unsigned NUM_DEV = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DEV-1:0]    req_rqst,
    input  logic [NUM_DEV-1:0]    req_rd_wr,
    input  logic [16*NUM_DEV-1:0] req_addr,
    input  logic [16*NUM_DEV-1:0] req_nwords,
    input  logic [16*NUM_DEV-1:0] req_dout,
    input  logic [NUM_DEV-1:0]    req_dev_ack,
    output logic [NUM_DEV-1:0]    dev_dma_ack,
    output logic [NUM_DEV-1:0]    dev_end_flag,
    output logic [15:0]           dev_din,
    output logic                  dma_rqst,
    output logic                  dma_rd_wr,
    output logic [15:0]           dma_start_address,
    output logic [15:0]           dma_num_words,
    output logic [15:0]           dev_out,
    output logic                  dev_ack,
    input  logic                  dma_ack,
    input  logic                  dma_end_flag,
    input  logic [15:0]           dev_in,
    output logic                  arb_busy,
    output logic [ID_W-1:0]       arb_grant_id
);

    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {IDLE, SETUP, BUSY, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;

    logic [DW-1:0] addr_a   [NUM_DEV];
    logic [DW-1:0] nwords_a [NUM_DEV];
    logic [DW-1:0] dout_a   [NUM_DEV];

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_unpack
        assign addr_a[g]   = req_addr[g*DW +: DW];
        assign nwords_a[g] = req_nwords[g*DW +: DW];
        assign dout_a[g]   = req_dout[g*DW +: DW];
    end

    logic gnt_rqst;
    assign gnt_rqst = req_rqst[grant_id];

    // Rotate requests so rr_ptr sits at bit 0, pick lowest set bit, map back.
    logic [2*NUM_DEV-1:0] dbl;
    logic [NUM_DEV-1:0]   rot;
    logic [ID_W-1:0]      off;
    logic [ID_W:0]        sum;
    logic [ID_W-1:0]      sel;

    always_comb begin
        dbl = {req_rqst, req_rqst};
        rot = NUM_DEV'(dbl >> rr_ptr);
        off = '0;
        for (int k = int'(NUM_DEV) - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_DEV)) sum = sum - (ID_W+1)'(NUM_DEV);
        sel = sum[ID_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_rqst) begin
                        grant_id <= sel;
                        state    <= SETUP;
                    end
                end
                SETUP: state <= BUSY;
                BUSY: begin
                    if (dma_end_flag || !gnt_rqst) state <= DONE;
                end
                DONE: begin
                    if (!dma_end_flag && !gnt_rqst) begin
                        state  <= IDLE;
                        rr_ptr <= (grant_id == ID_W'(NUM_DEV - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bundle mux and ack/end demux, all keyed off the registered grant.
    always_comb begin
        dma_rqst          = 1'b0;
        dma_rd_wr         = 1'b0;
        dma_start_address = '0;
        dma_num_words     = '0;
        dev_out           = '0;
        dev_ack           = 1'b0;
        dev_dma_ack       = '0;
        dev_end_flag      = '0;
        case (state)
            SETUP: begin
                dma_rd_wr         = req_rd_wr[grant_id];
                dma_start_address = addr_a[grant_id];
                dma_num_words     = nwords_a[grant_id];
                dev_out           = dout_a[grant_id];
            end
            BUSY: begin
                dma_rqst                = gnt_rqst;
                dma_rd_wr               = req_rd_wr[grant_id];
                dma_start_address       = addr_a[grant_id];
                dma_num_words           = nwords_a[grant_id];
                dev_out                 = dout_a[grant_id];
                dev_ack                 = req_dev_ack[grant_id];
                dev_dma_ack[grant_id]   = dma_ack;
                dev_end_flag[grant_id]  = dma_end_flag;
            end
            DONE: dev_end_flag[grant_id] = dma_end_flag;
            default: ;
        endcase
    end

    assign dev_din      = dev_in;
    assign arb_busy     = (state != IDLE);
    assign arb_grant_id = grant_id;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed self-checking bench for dma_req_arbiter with NUM_DEV = 4.
module tb_dma_req_arbiter;

    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_rqst, req_rd_wr, req_dev_ack;
    logic [16*N-1:0] req_addr, req_nwords, req_dout;
    logic [N-1:0]    dev_dma_ack, dev_end_flag;
    logic [15:0]     dev_din, dma_start_address, dma_num_words, dev_out, dev_in;
    logic            dma_rqst, dma_rd_wr, dev_ack, dma_ack, dma_end_flag, arb_busy;
    logic [1:0]      arb_grant_id;

    logic [15:0] a_addr [N];
    logic [15:0] a_nw   [N];
    logic [15:0] a_dout [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*16 +: 16]   = a_addr[g];
        assign req_nwords[g*16 +: 16] = a_nw[g];
        assign req_dout[g*16 +: 16]   = a_dout[g];
    end

    int checks = 0;
    int errors = 0;

    dma_req_arbiter #(.NUM_DEV(4), .ID_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_rqst(req_rqst), .req_rd_wr(req_rd_wr), .req_addr(req_addr),
        .req_nwords(req_nwords), .req_dout(req_dout), .req_dev_ack(req_dev_ack),
        .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag), .dev_din(dev_din),
        .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr), .dma_start_address(dma_start_address),
        .dma_num_words(dma_num_words), .dev_out(dev_out), .dev_ack(dev_ack),
        .dma_ack(dma_ack), .dma_end_flag(dma_end_flag), .dev_in(dev_in),
        .arb_busy(arb_busy), .arb_grant_id(arb_grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_devs();
        for (int i = 0; i < int'(N); i++) begin
            a_addr[i] = 16'(32'h1000 + i * 256);
            a_nw[i]   = 16'(i + 1);
            a_dout[i] = 16'(32'hA000 + i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_rqst = '0; req_rd_wr = '0; req_dev_ack = '0;
        dma_ack = 1'b0; dma_end_flag = 1'b0; dev_in = '0;
        init_devs();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_rqst();
        bit ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (dma_rqst) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_rqst: dma_rqst=%b required 1 within 20 clocks", dma_rqst);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (!arb_busy) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: arb_busy=%b required 0 within 20 clocks", arb_busy);
        end
    endtask

    // One full operation for device id: grant and bundle checks, end pulse, release.
    task automatic run_op(input int id);
        logic [N-1:0] m;
        m = 4'b0001 << id;
        wait_rqst();
        checks += 4;
        if (arb_grant_id !== 2'(id)) begin errors++; $display("FAIL op_grant: got %0d required %0d", arb_grant_id, id); end
        if (dma_start_address !== a_addr[id]) begin errors++; $display("FAIL op_addr: got %h required %h", dma_start_address, a_addr[id]); end
        if (dma_num_words !== a_nw[id]) begin errors++; $display("FAIL op_nwords: got %h required %h", dma_num_words, a_nw[id]); end
        if (dev_out !== a_dout[id]) begin errors++; $display("FAIL op_dout: got %h required %h", dev_out, a_dout[id]); end
        dma_end_flag = 1'b1;
        #1;
        checks++;
        if (dev_end_flag !== m) begin errors++; $display("FAIL op_end_route: got %b required %b", dev_end_flag, m); end
        tick();
        dma_end_flag = 1'b0;
        req_rqst = req_rqst & ~m;
        wait_idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (dma_rqst !== 1'b0) begin errors++; $display("FAIL reset_rqst: got %b required 0", dma_rqst); end
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", arb_busy); end
        if (arb_grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d required 0", arb_grant_id); end
        if (dev_dma_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b required 0000", dev_dma_ack); end
        if (dma_start_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h required 0000", dma_start_address); end
        dev_in = 16'h1234;
        #1;
        if (dev_din !== 16'h1234) begin errors++; $display("FAIL reset_din: got %h required 1234", dev_din); end
    endtask

    task automatic test_single();
        do_reset();
        a_addr[0] = 16'h0200; a_nw[0] = 16'd4;
        req_rqst = 4'b0001;
        tick();
        checks += 3;
        if (arb_busy !== 1'b1) begin errors++; $display("FAIL setup_busy: got %b required 1", arb_busy); end
        if (dma_rqst !== 1'b0) begin errors++; $display("FAIL setup_rqst: got %b required 0", dma_rqst); end
        if (dma_start_address !== 16'h0200) begin errors++; $display("FAIL setup_addr: got %h required 0200", dma_start_address); end
        tick();
        checks += 3;
        if (dma_rqst !== 1'b1) begin errors++; $display("FAIL busy_rqst: got %b required 1", dma_rqst); end
        if (dma_start_address !== 16'h0200) begin errors++; $display("FAIL busy_addr: got %h required 0200", dma_start_address); end
        if (dma_num_words !== 16'd4) begin errors++; $display("FAIL busy_nwords: got %h required 0004", dma_num_words); end
        dma_end_flag = 1'b1;
        #1;
        checks++;
        if (dev_end_flag !== 4'b0001) begin errors++; $display("FAIL end_route: got %b required 0001", dev_end_flag); end
        tick();
        checks += 2;
        if (dma_rqst !== 1'b0) begin errors++; $display("FAIL done_rqst: got %b required 0", dma_rqst); end
        if (dev_end_flag !== 4'b0001) begin errors++; $display("FAIL done_end_route: got %b required 0001", dev_end_flag); end
        dma_end_flag = 1'b0;
        req_rqst = 4'b0000;
        tick();
        checks++;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b required 0", arb_busy); end
        // rr_ptr now 1: with dev0 and dev1 both requesting, dev1 must win.
        req_rqst = 4'b0011;
        run_op(1);
        run_op(0);
        init_devs();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_rqst = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_op(order[k]);
            if (k < 4) req_rqst = req_rqst | (4'b0001 << order[k]);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req_rqst = 4'b0100;
        wait_rqst();
        checks++;
        if (arb_grant_id !== 2'd2) begin errors++; $display("FAIL np_grant2: got %0d required 2", arb_grant_id); end
        req_rqst = 4'b0110;
        dma_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks += 2;
            if (dev_dma_ack !== 4'b0100) begin errors++; $display("FAIL np_ack_route: got %b required 0100", dev_dma_ack); end
            if (arb_grant_id !== 2'd2) begin errors++; $display("FAIL np_hold: got %0d required 2", arb_grant_id); end
        end
        dma_ack = 1'b0;
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        req_rqst = 4'b0010;
        tick();
        checks += 2;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL np_idle: got %b required 0", arb_busy); end
        if (arb_grant_id !== 2'd2) begin errors++; $display("FAIL np_last_grant: got %0d required 2", arb_grant_id); end
        tick();
        checks += 2;
        if (arb_grant_id !== 2'd1) begin errors++; $display("FAIL np_grant1: got %0d required 1", arb_grant_id); end
        if (dma_rqst !== 1'b0) begin errors++; $display("FAIL np_setup_rqst: got %b required 0", dma_rqst); end
        run_op(1);
    endtask

    task automatic test_read_ack();
        do_reset();
        req_rd_wr = 4'b1000;
        req_dev_ack = 4'b1000;
        req_rqst = 4'b1000;
        wait_rqst();
        checks += 3;
        if (arb_grant_id !== 2'd3) begin errors++; $display("FAIL rd_grant: got %0d required 3", arb_grant_id); end
        if (dma_rd_wr !== 1'b1) begin errors++; $display("FAIL rd_dir: got %b required 1", dma_rd_wr); end
        if (dev_ack !== 1'b1) begin errors++; $display("FAIL rd_dev_ack: got %b required 1", dev_ack); end
        dma_ack = 1'b1;
        dev_in = 16'hBEEF;
        #1;
        checks += 2;
        if (dev_dma_ack !== 4'b1000) begin errors++; $display("FAIL rd_ack_route: got %b required 1000", dev_dma_ack); end
        if (dev_din !== 16'hBEEF) begin errors++; $display("FAIL rd_din: got %h required beef", dev_din); end
        dma_ack = 1'b0;
        #1;
        checks++;
        if (dev_dma_ack !== 4'b0000) begin errors++; $display("FAIL rd_ack_low: got %b required 0000", dev_dma_ack); end
        run_op(3);
    endtask

    task automatic test_reset_busy();
        do_reset();
        req_rqst = 4'b0011;
        wait_rqst();
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (dma_rqst !== 1'b0) begin errors++; $display("FAIL rb_rqst: got %b required 0", dma_rqst); end
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL rb_busy: got %b required 0", arb_busy); end
        if (dev_end_flag !== 4'b0000) begin errors++; $display("FAIL rb_end: got %b required 0000", dev_end_flag); end
        req_rqst = 4'b0010;
        tick();
        reset = 1'b0;
        tick();
        run_op(1);
    endtask

    task automatic test_abort_setup();
        do_reset();
        req_rqst = 4'b0011;
        tick();
        checks += 2;
        if (arb_busy !== 1'b1) begin errors++; $display("FAIL ab_setup: got %b required 1", arb_busy); end
        if (arb_grant_id !== 2'd0) begin errors++; $display("FAIL ab_grant0: got %0d required 0", arb_grant_id); end
        req_rqst = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dma_rqst !== 1'b0) begin errors++; $display("FAIL ab_rqst: got %b required 0", dma_rqst); end
        end
        checks++;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL ab_idle: got %b required 0", arb_busy); end
        run_op(1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_rqst = 4'b0001;
        wait_rqst();
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        // Requester holding rqst after its end flag keeps the arbiter in DONE.
        for (int c = 0; c < 2; c++) begin
            tick();
            checks += 2;
            if (arb_busy !== 1'b1) begin errors++; $display("FAIL bb_hold_busy: got %b required 1", arb_busy); end
            if (dma_rqst !== 1'b0) begin errors++; $display("FAIL bb_hold_rqst: got %b required 0", dma_rqst); end
        end
        req_rqst = 4'b0000;
        tick();
        checks++;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL bb_idle: got %b required 0", arb_busy); end
        req_rqst = 4'b0001;
        tick();
        tick();
        checks += 2;
        if (dma_rqst !== 1'b1) begin errors++; $display("FAIL bb_regrant: got %b required 1", dma_rqst); end
        if (arb_grant_id !== 2'd0) begin errors++; $display("FAIL bb_grant: got %0d required 0", arb_grant_id); end
        run_op(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_read_ack();
        test_reset_busy();
        test_abort_setup();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
